// File: rtl/rvv_fifo_pkg.sv
// Shared types and helpers for the RVV FIFO read-side controller.
package rvv_fifo_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } pop_state_e;

  localparam int MAX_POP = 2;

  // Smaller of two 2-bit pop counts.
  function automatic logic [1:0] pop_min(input logic [1:0] a, input logic [1:0] b);
    if (a < b) begin
      pop_min = a;
    end else begin
      pop_min = b;
    end
  endfunction

endpackage

// File: rtl/rvv_fifo_pop_drain_if.sv
// FIFO read port plus downstream valid/ready stream of the pop/drain controller.
interface rvv_fifo_pop_drain_if #(
  parameter int DWIDTH = 32
);
  logic              empty;
  logic              almost_empty;
  logic [DWIDTH-1:0] pop_data0;
  logic [DWIDTH-1:0] pop_data1;
  logic              pop0;
  logic              pop1;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;

  modport master (
    input  empty, almost_empty, pop_data0, pop_data1, out_ready,
    output pop0, pop1, out_valid, out_data
  );

  modport slave (
    output empty, almost_empty, pop_data0, pop_data1, out_ready,
    input  pop0, pop1, out_valid, out_data
  );
endinterface

// File: rtl/rvv_fifo_obuf.sv
// Circular output buffer: up to two writes and one read per cycle, synchronous clear.
module rvv_fifo_obuf #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic [1:0]        wr_n_i,
  input  logic [DWIDTH-1:0] wr_data0_i,
  input  logic [DWIDTH-1:0] wr_data1_i,
  input  logic              rd_en_i,
  output logic [DWIDTH-1:0] rd_data_o,
  output logic [CW-1:0]     count_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1_s;
  logic [CW-1:0]     count_q, count_d;

  // Pointer and occupancy next-state; pointer arithmetic wraps modulo DEPTH.
  always_comb begin
    wr_ptr1_s = wr_ptr_q + PW'(1);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(wr_n_i);
      rd_ptr_d = rd_ptr_q + PW'(rd_en_i);
      count_d  = count_q + CW'(wr_n_i) - CW'(rd_en_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the read port shows zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_n_i != 2'd0) begin
        mem_q[wr_ptr_q] <= wr_data0_i;
      end
      if (wr_n_i == 2'd2) begin
        mem_q[wr_ptr1_s] <= wr_data1_i;
      end
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/rvv_fifo_pop_drain.sv
// Read-side controller of the 2-read-port RVV FIFO: pops up to two head entries
// per cycle into a small buffer and drains it over a valid/ready stream.
module rvv_fifo_pop_drain
  import rvv_fifo_pkg::*;
#(
  parameter int DWIDTH     = 32,
  parameter int OBUF_DEPTH = 4,
  parameter int CNT_W      = 32,
  localparam int CW        = $clog2(OBUF_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hold,
  input  logic                 flush,
  rvv_fifo_pop_drain_if.master bus,
  output logic [CNT_W-1:0]     pop_count,
  output logic                 busy
);

  pop_state_e       state_q, state_d;
  logic [1:0]       avail_s, room_s, n_s;
  logic [CW-1:0]    count_s, free_s;
  logic             hs_s;
  logic [CNT_W-1:0] pop_count_q, pop_count_d;
  logic [CNT_W:0]   pop_sum_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush wins over hold; every state leaves to HOLD or RUN by hold.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN, HOLD, FLUSH: state_d = hold ? HOLD : RUN;
        default:          state_d = RUN;
      endcase
    end
  end

  // Pop arbitration and stream outputs. Free space uses the registered count only,
  // so out_ready never reaches pop0/pop1 combinationally.
  always_comb begin
    avail_s = 2'd0;
    room_s  = 2'd0;
    n_s     = 2'd0;
    free_s  = CW'(OBUF_DEPTH) - count_s;
    if (bus.empty) begin
      avail_s = 2'd0;
    end else if (bus.almost_empty) begin
      avail_s = 2'd1;
    end else begin
      avail_s = 2'd2;
    end
    if (free_s >= CW'(MAX_POP)) begin
      room_s = 2'(MAX_POP);
    end else begin
      room_s = free_s[1:0];
    end
    if (rst_n && (state_q == RUN) && !flush) begin
      n_s = pop_min(avail_s, room_s);
    end else begin
      n_s = 2'd0;
    end
    bus.pop0      = (n_s != 2'd0);
    bus.pop1      = (n_s == 2'd2);
    bus.out_valid = (count_s != '0);
    hs_s          = bus.out_valid && bus.out_ready && !flush;
    busy          = (count_s != '0) || (state_q != RUN);
  end

  // Saturating popped-entry total.
  always_comb begin
    pop_sum_s = {1'b0, pop_count_q} + (CNT_W + 1)'(n_s);
    if (pop_sum_s[CNT_W]) begin
      pop_count_d = '1;
    end else begin
      pop_count_d = pop_sum_s[CNT_W-1:0];
    end
  end

  // Popped-entry counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count_q <= '0;
    end else begin
      pop_count_q <= pop_count_d;
    end
  end

  assign pop_count = pop_count_q;

  rvv_fifo_obuf #(
    .DWIDTH (DWIDTH),
    .DEPTH  (OBUF_DEPTH)
  ) u_obuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (flush),
    .wr_n_i     (n_s),
    .wr_data0_i (bus.pop_data0),
    .wr_data1_i (bus.pop_data1),
    .rd_en_i    (hs_s),
    .rd_data_o  (bus.out_data),
    .count_o    (count_s)
  );

endmodule

// File: tb/tb_rvv_fifo_pop_drain.sv
// Directed bench for rvv_fifo_pop_drain with a FIFO model and an in-order data scoreboard.
module tb_rvv_fifo_pop_drain;
  import rvv_fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold;
  logic        flush;
  logic [31:0] pop_count;
  logic        busy;

  rvv_fifo_pop_drain_if #(.DWIDTH(32)) bus ();

  rvv_fifo_pop_drain #(
    .DWIDTH     (32),
    .OBUF_DEPTH (4),
    .CNT_W      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (hold),
    .flush     (flush),
    .bus       (bus),
    .pop_count (pop_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] fifo_q [$];
  logic [31:0] sb_q [$];
  int          hist [$];
  int          m_count, m_pop_count, obs_n, hs_cnt, viol, guard;
  pop_state_e  m_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.empty        = (fifo_q.size() == 0);
    bus.almost_empty = (fifo_q.size() == 1);
    bus.pop_data0    = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
    bus.pop_data1    = (fifo_q.size() > 1) ? fifo_q[1] : 32'd0;
  endtask

  task automatic load(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + 32'(i));
    drive_fifo();
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle();
    int          avail, room, exp_n;
    logic        hs;
    logic [31:0] exp_d;
    @(negedge clk);
    avail = (fifo_q.size() == 0) ? 0 : (fifo_q.size() == 1) ? 1 : 2;
    room  = 4 - m_count;
    if (room > 2) room = 2;
    exp_n = (m_state == RUN && !flush) ? ((avail < room) ? avail : room) : 0;
    obs_n = int'(bus.pop0) + int'(bus.pop1);
    hist.push_back(obs_n);
    if (bus.almost_empty && bus.pop1) viol++;
    chk("pop0", 64'(bus.pop0), 64'(exp_n >= 1));
    chk("pop1", 64'(bus.pop1), 64'(exp_n == 2));
    chk("out_valid", 64'(bus.out_valid), 64'(m_count != 0));
    chk("busy", 64'(busy), 64'((m_count != 0) || (m_state != RUN)));
    chk("pop_count", 64'(pop_count), 64'(m_pop_count));
    hs = (m_count != 0) && bus.out_ready && !flush;
    if (hs) begin
      exp_d = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
      chk("out_data", 64'(bus.out_data), 64'(exp_d));
      hs_cnt++;
    end
    if (flush) begin
      m_count = 0;
      sb_q.delete();
    end else begin
      m_count = m_count + exp_n - int'(hs);
      for (int i = 0; i < exp_n; i++) sb_q.push_back(fifo_q.pop_front());
    end
    m_pop_count = m_pop_count + exp_n;
    m_state = flush ? FLUSH : (hold ? HOLD : RUN);
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive_fifo();
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  task automatic model_reset();
    m_count = 0; m_pop_count = 0; m_state = RUN; sb_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    hs_cnt = 0; viol = 0;
    model_reset();
    drive_fifo();
    #12;
    chk("rst_pop0", 64'(bus.pop0), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", 64'(bus.out_data), 64'd0);
    chk("rst_cnt", 64'(pop_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: five entries, consumer always ready
    bus.out_ready = 1'b1;
    load(5, 32'hA0);
    hist.delete();
    run(6);
    chk("t1_n0", 64'(hist[0]), 64'd2);
    chk("t1_n1", 64'(hist[1]), 64'd2);
    chk("t1_n2", 64'(hist[2]), 64'd1);
    chk("t1_hs", 64'(hs_cnt), 64'd5);
    chk("t1_pop_count", 64'(pop_count), 64'd5);

    // 2: single entry, pop1 must stay low
    hist.delete();
    load(1, 32'hB0);
    run(3);
    chk("t2_n0", 64'(hist[0]), 64'd1);
    chk("t2_n1", 64'(hist[1]), 64'd0);
    chk("t2_ae_pop1", 64'(viol), 64'd0);

    // 3: consumer stalled, buffer fills to depth
    bus.out_ready = 1'b0;
    hs_cnt = 0;
    hist.delete();
    load(10, 32'hC0);
    run(4);
    chk("t3_n0", 64'(hist[0]), 64'd2);
    chk("t3_n1", 64'(hist[1]), 64'd2);
    chk("t3_n2", 64'(hist[2]), 64'd0);
    chk("t3_n3", 64'(hist[3]), 64'd0);
    chk("t3_data", 64'(bus.out_data), 64'h0C0);
    chk("t3_pop0", 64'(bus.pop0), 64'd0);

    // 4: full buffer drains; pointers wrap over ten entries
    bus.out_ready = 1'b1;
    hist.delete();
    run(2);
    chk("t4_n0", 64'(hist[0]), 64'd0);
    chk("t4_n1", 64'(hist[1]), 64'd1);
    guard = 0;
    while ((fifo_q.size() != 0 || m_count != 0) && guard < 40) begin
      cycle();
      guard++;
    end
    chk("t4_timeout", 64'(guard < 40), 64'd1);
    chk("t4_hs", 64'(hs_cnt), 64'd10);

    // 5: flush with three buffered entries
    bus.out_ready = 1'b0;
    load(3, 32'hD0);
    run(2);
    load(2, 32'hE0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    hist.delete();
    run(1);
    chk("t5_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd1);
    run(2);
    chk("t5_n0", 64'(hist[0]), 64'd0);
    chk("t5_n1", 64'(hist[1]), 64'd0);
    chk("t5_n2", 64'(hist[2]), 64'd2);
    run(3);

    // 6: hold with two buffered entries, then reset mid-stream
    bus.out_ready = 1'b0;
    load(2, 32'hF0);
    hold = 1'b1;
    run(1);
    load(2, 32'hF8);
    bus.out_ready = 1'b1;
    hs_cnt = 0;
    hist.delete();
    run(4);
    chk("t6_n_sum", 64'(hist[0] + hist[1] + hist[2] + hist[3]), 64'd0);
    chk("t6_hs", 64'(hs_cnt), 64'd2);
    chk("t6_busy", 64'(busy), 64'd1);
    hold = 1'b0;
    run(2);
    load(3, 32'h90);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_pop0", 64'(bus.pop0), 64'd0);
    chk("t6_rst_pop1", 64'(bus.pop1), 64'd0);
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_data", 64'(bus.out_data), 64'd0);
    chk("t6_rst_cnt", 64'(pop_count), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_fifo();
    run(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
